// File: rtl/us_dist_filter.sv
// Per-channel EMA smoothing and stale tracking of HC-SR04 tick counts, with a snapshot that holds while tx_busy is high.
// Optional build macro US_FILT_SPIKE_REJECT_EN enables single-sample spike rejection.
module us_dist_filter #(
  parameter int unsigned NUM_CH      = 9,
  parameter int unsigned SHIFT       = 2,
  parameter int unsigned MAX_COUNT   = 3800,
  parameter int unsigned STALE_LIMIT = 4,
  parameter int unsigned SPIKE_LIMIT = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16*NUM_CH-1:0] ticks,
  input  logic [NUM_CH-1:0]    valid,
  input  logic                 tx_busy,
  output logic [16*NUM_CH-1:0] dist_out,
  output logic [NUM_CH-1:0]    primed,
  output logic [NUM_CH-1:0]    stale,
  output logic                 update_pulse
);

  localparam int unsigned ACC_W = 16 + SHIFT;
  localparam int unsigned PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] valid_q, edge_det, pending, clr;
  logic [15:0]       sample [NUM_CH];
  logic [ACC_W-1:0]  acc    [NUM_CH];
  logic [3:0]        miss   [NUM_CH];
  logic [NUM_CH-1:0] primed_i, stale_i;
  logic [PW-1:0]     p;
  logic              dirty, proc, snap;

  logic [15:0]       s;
  logic [ACC_W-1:0]  acc_cur, acc_nxt;
  logic [3:0]        miss_nxt;
  logic              primed_nxt, stale_nxt;

`ifdef US_FILT_SPIKE_REJECT_EN
  logic [NUM_CH-1:0] spike;
  logic              spike_nxt;
  logic [15:0]       avg_cur, diff;
`endif

  assign edge_det = valid & ~valid_q;
  assign proc     = pending[p];
  assign snap     = dirty & ~tx_busy;

  // Only channel p is evaluated each cycle; its new state is written back on the next edge.
  always_comb begin
    s          = sample[p];
    acc_cur    = acc[p];
    acc_nxt    = acc_cur;
    miss_nxt   = miss[p];
    primed_nxt = primed_i[p];
    stale_nxt  = stale_i[p];
    clr        = '0;
    clr[p]     = proc;
`ifdef US_FILT_SPIKE_REJECT_EN
    spike_nxt  = 1'b0;
    avg_cur    = acc_cur[SHIFT +: 16];
    diff       = (s > avg_cur) ? (s - avg_cur) : (avg_cur - s);
`endif
    if (s >= 16'(MAX_COUNT)) begin
      if (miss[p] < 4'(STALE_LIMIT)) miss_nxt = miss[p] + 4'd1;
      if (miss_nxt == 4'(STALE_LIMIT)) begin
        stale_nxt  = 1'b1;
        primed_nxt = 1'b0;
      end
    end else if (!primed_i[p]) begin
      acc_nxt    = ACC_W'(s) << SHIFT;
      primed_nxt = 1'b1;
      miss_nxt   = '0;
      stale_nxt  = 1'b0;
`ifdef US_FILT_SPIKE_REJECT_EN
    end else if (diff > 16'(SPIKE_LIMIT)) begin
      if (!spike[p]) begin
        spike_nxt = 1'b1;
      end else begin
        acc_nxt   = ACC_W'(s) << SHIFT;
        miss_nxt  = '0;
        stale_nxt = 1'b0;
      end
`endif
    end else begin
      acc_nxt   = acc_cur + ACC_W'(s) - (acc_cur >> SHIFT);
      miss_nxt  = '0;
      stale_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      pending      <= '0;
      primed_i     <= '0;
      stale_i      <= '0;
      p            <= '0;
      dirty        <= 1'b0;
      dist_out     <= '0;
      primed       <= '0;
      stale        <= '0;
      update_pulse <= 1'b0;
`ifdef US_FILT_SPIKE_REJECT_EN
      spike        <= '0;
`endif
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sample[i] <= '0;
        acc[i]    <= '0;
        miss[i]   <= '0;
      end
    end else begin
      valid_q <= valid;
      p       <= (p == PW'(NUM_CH - 1)) ? '0 : p + 1'b1;
      // A fresh edge on the channel being processed keeps it pending for the next pass.
      pending <= (pending & ~clr) | edge_det;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (edge_det[i]) sample[i] <= ticks[16*i +: 16];
      end
      if (proc) begin
        acc[p]      <= acc_nxt;
        miss[p]     <= miss_nxt;
        primed_i[p] <= primed_nxt;
        stale_i[p]  <= stale_nxt;
`ifdef US_FILT_SPIKE_REJECT_EN
        spike[p]    <= spike_nxt;
`endif
      end
      dirty        <= proc | (dirty & ~snap);
      update_pulse <= snap;
      if (snap) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          dist_out[16*i +: 16] <= acc[i][SHIFT +: 16];
        end
        primed <= primed_i;
        stale  <= stale_i;
      end
    end
  end

endmodule
